// File: rtl/snow64_long_div_param_radix.sv
// Iterative radix-2^RADIX_BITS long divider with signed/unsigned modes, remainder output and
// divide-by-zero flag. One quotient digit per cycle, selected from a registered multiples table.
module snow64_long_div_param_radix #(
  parameter int WIDTH_A    = 16,
  parameter int WIDTH_B    = 8,
  parameter int RADIX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_start,
  input  logic               in_signed,
  input  logic [WIDTH_A-1:0] in_a,
  input  logic [WIDTH_B-1:0] in_b,
  output logic               out_can_accept_cmd,
  output logic               out_data_valid,
  output logic [WIDTH_A-1:0] out_quot,
  output logic [WIDTH_B-1:0] out_rem,
  output logic               out_div_by_zero
);

  localparam int N_ITER = WIDTH_A / RADIX_BITS;
  localparam int IW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int WM     = WIDTH_B + RADIX_BITS;
  localparam int ND     = 1 << RADIX_BITS;

  typedef enum logic {IDLE, WORK} state_t;
  state_t state_reg, state_next;

  logic                  accept;
  logic                  sign_a, sign_b;
  logic [WIDTH_A-1:0]    mag_a;
  logic [WIDTH_B-1:0]    mag_b;

  logic [WM-1:0]         mult_reg [ND];
  logic [WIDTH_A-1:0]    a_sh_reg;
  logic [WIDTH_B-1:0]    rem_reg;
  logic [WIDTH_A-1:0]    quot_acc_reg;
  logic [IW-1:0]         iter_reg;
  logic                  neg_q_reg, neg_r_reg, dz_reg;
  logic [WIDTH_B-1:0]    raw_lo_reg;

  logic [WM-1:0]         cur;
  logic [RADIX_BITS-1:0] digit, cand;
  logic [WIDTH_B-1:0]    rem_step;
  logic [WIDTH_A-1:0]    quot_step;
  logic [WIDTH_A-1:0]    quot_fix;
  logic [WIDTH_B-1:0]    rem_fix;

  assign accept = in_start && out_can_accept_cmd;

  // W-bit two's-complement negation of MIN yields MIN, which is the exact unsigned magnitude.
  assign sign_a = in_signed & in_a[WIDTH_A-1];
  assign sign_b = in_signed & in_b[WIDTH_B-1];
  assign mag_a  = sign_a ? (~in_a + WIDTH_A'(1)) : in_a;
  assign mag_b  = sign_b ? (~in_b + WIDTH_B'(1)) : in_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_start)        state_next = WORK;
      WORK:    if (iter_reg == '0)  state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    out_can_accept_cmd = (state_reg == IDLE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_mult
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mult_reg[gi] <= '0;
        else if (accept) mult_reg[gi] <= WM'(gi) * WM'(mag_b);
      end
    end
  endgenerate

  // Binary search over the monotone multiples table; with a zero divisor every entry is
  // zero and the search settles on the all-ones digit.
  always_comb begin
    cur   = {rem_reg, a_sh_reg[WIDTH_A-1 -: RADIX_BITS]};
    digit = '0;
    cand  = '0;
    for (int i = RADIX_BITS - 1; i >= 0; i--) begin
      cand = digit | (RADIX_BITS'(1) << i);
      if (mult_reg[cand] <= cur) digit = cand;
    end
    rem_step  = WIDTH_B'(cur - mult_reg[digit]);
    quot_step = (quot_acc_reg << RADIX_BITS) | WIDTH_A'(digit);
    quot_fix  = dz_reg ? '1 : (neg_q_reg ? (~quot_step + WIDTH_A'(1)) : quot_step);
    rem_fix   = dz_reg ? raw_lo_reg : (neg_r_reg ? (~rem_step + WIDTH_B'(1)) : rem_step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg        <= '0;
      rem_reg         <= '0;
      quot_acc_reg    <= '0;
      iter_reg        <= '0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      dz_reg          <= 1'b0;
      raw_lo_reg      <= '0;
      out_quot        <= '0;
      out_rem         <= '0;
      out_div_by_zero <= 1'b0;
      out_data_valid  <= 1'b0;
    end else if (accept) begin
      a_sh_reg        <= mag_a;
      rem_reg         <= '0;
      quot_acc_reg    <= '0;
      iter_reg        <= IW'(N_ITER - 1);
      neg_q_reg       <= in_signed & (in_a[WIDTH_A-1] ^ in_b[WIDTH_B-1]);
      neg_r_reg       <= sign_a;
      dz_reg          <= (in_b == '0);
      raw_lo_reg      <= in_a[WIDTH_B-1:0];
      out_data_valid  <= 1'b0;
    end else if (state_reg == WORK) begin
      a_sh_reg        <= a_sh_reg << RADIX_BITS;
      rem_reg         <= rem_step;
      quot_acc_reg    <= quot_step;
      iter_reg        <= iter_reg - IW'(1);
      if (iter_reg == '0) begin
        out_quot        <= quot_fix;
        out_rem         <= rem_fix;
        out_div_by_zero <= dz_reg;
        out_data_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snow64_long_div_param_radix.sv
// Self-checking bench: table vectors plus random operands against a behavioural golden model,
// results matched through a scoreboard queue when out_data_valid rises.
module tb_snow64_long_div_param_radix;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic        in_signed = 1'b0;
  logic [15:0] in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_can_accept_cmd, out_data_valid, out_div_by_zero;
  logic [15:0] out_quot;
  logic [7:0]  out_rem;

  snow64_long_div_param_radix #(.WIDTH_A(16), .WIDTH_B(8), .RADIX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .out_can_accept_cmd(out_can_accept_cmd),
    .out_data_valid(out_data_valid), .out_quot(out_quot), .out_rem(out_rem),
    .out_div_by_zero(out_div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t golden(input logic s, input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    int   sa, sb;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = a[7:0]; e.dz = 1'b1;
    end else if (s) begin
      sa = $signed(a); sb = $signed(b);
      e.q = 16'(sa / sb); e.r = 8'(sa % sb); e.dz = 1'b0;
    end else begin
      e.q = a / {8'd0, b}; e.r = 8'(a % {8'd0, b}); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: one result per rising edge of valid.
  always @(negedge clk) begin
    if (rst_n && out_data_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: got q=0x%0h r=0x%0h required no result", out_quot, out_rem);
      end else begin
        mon_e = sb_q.pop_front();
        $display("result q=0x%04h r=0x%02h dz=%0b (req q=0x%04h r=0x%02h dz=%0b)",
                 out_quot, out_rem, out_div_by_zero, mon_e.q, mon_e.r, mon_e.dz);
        check("quot", 32'(out_quot), 32'(mon_e.q));
        check("rem", 32'(out_rem), 32'(mon_e.r));
        check("div_by_zero", 32'(out_div_by_zero), 32'(mon_e.dz));
      end
    end
    prev_valid <= out_data_valid && rst_n;
  end

  task automatic check_reset(input string tag);
    check({tag, "_can_accept"}, 32'(out_can_accept_cmd), 32'd1);
    check({tag, "_valid"}, 32'(out_data_valid), 32'd0);
    check({tag, "_quot"}, 32'(out_quot), 32'd0);
    check({tag, "_rem"}, 32'(out_rem), 32'd0);
    check({tag, "_dz"}, 32'(out_div_by_zero), 32'd0);
  endtask

  // Issues one command, pushes its expectation, and checks handshake timing.
  // With poke set, in_start is held high during the busy cycles with junk operands.
  task automatic run_cmd(input logic s, input logic [15:0] a, input logic [7:0] b,
                         input exp_t e, input bit poke);
    int w, lat;
    w = 0;
    @(negedge clk);
    while (!out_can_accept_cmd && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!out_can_accept_cmd) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got can_accept=0 required 1 within 40 cycles");
      return;
    end
    in_signed = s; in_a = a; in_b = b; in_start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_start = 1'b0;
    in_a = 16'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom);
    check("valid_clear_on_accept", 32'(out_data_valid), 32'd0);
    lat = 0;
    while (!out_data_valid && lat < 20) begin
      check("busy_can_accept", 32'(out_can_accept_cmd), 32'd0);
      in_start = (poke && lat >= 1) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    in_start = 1'b0;
    check("latency", 32'(lat), 32'd4);
  endtask

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic        rs;
    logic [15:0] ra;
    logic [7:0]  rb;

    vecs[0] = '{1'b0, 16'd1000, 8'd7,   16'd142,  8'd6,   1'b0};
    vecs[1] = '{1'b1, 16'hFC18, 8'h07,  16'hFF72, 8'hFA,  1'b0};
    vecs[2] = '{1'b1, 16'd1000, 8'hF9,  16'hFF72, 8'h06,  1'b0};
    vecs[3] = '{1'b1, 16'h8000, 8'hFF,  16'h8000, 8'h00,  1'b0};
    vecs[4] = '{1'b0, 16'hFFFF, 8'h01,  16'hFFFF, 8'h00,  1'b0};
    vecs[5] = '{1'b0, 16'h1234, 8'h00,  16'hFFFF, 8'h34,  1'b1};
    vecs[6] = '{1'b0, 16'd10,   8'd3,   16'd3,    8'd1,   1'b0};
    vecs[7] = '{1'b1, 16'h1234, 8'h00,  16'hFFFF, 8'h34,  1'b1};
    vecs[8] = '{1'b0, 16'hFFFF, 8'hFF,  16'h0101, 8'h00,  1'b0};
    vecs[9] = '{1'b1, 16'hFFFF, 8'h02,  16'h0000, 8'hFF,  1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, issued back to back.
    for (int i = 0; i < 10; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz;
      $display("cmd %0d s=%0b a=0x%04h b=0x%02h", i, vecs[i].sgn, vecs[i].a, vecs[i].b);
      run_cmd(vecs[i].sgn, vecs[i].a, vecs[i].b, e, 1'b0);
    end

    // Start on the very cycle valid is high.
    @(negedge clk);
    check("b2b_valid_high", 32'(out_data_valid), 32'd1);
    check("b2b_can_accept", 32'(out_can_accept_cmd), 32'd1);
    in_signed = 1'b0; in_a = 16'd77; in_b = 8'd5; in_start = 1'b1;
    sb_q.push_back(golden(1'b0, 16'd77, 8'd5));
    @(posedge clk);
    #1;
    in_start = 1'b0;
    check("b2b_accepted", 32'(out_can_accept_cmd), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_done", 32'(out_data_valid), 32'd1);

    // in_start while busy must be ignored.
    $display("cmd busy-poke s=0 a=500 b=9");
    run_cmd(1'b0, 16'd500, 8'd9, golden(1'b0, 16'd500, 8'd9), 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("poke_ignored_valid", 32'(out_data_valid), 32'd1);
      check("poke_ignored_idle", 32'(out_can_accept_cmd), 32'd1);
    end

    // Random operands against the golden model, salted with b=0 and MIN/-1.
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom);
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (i % 17 == 0) rb = 8'h00;
      if (i % 23 == 0) begin rs = 1'b1; ra = 16'h8000; rb = 8'hFF; end
      $display("cmd rnd%0d s=%0b a=0x%04h b=0x%02h", i, rs, ra, rb);
      run_cmd(rs, ra, rb, golden(rs, ra, rb), 1'b0);
    end

    // Reset mid-operation aborts the command without producing a result.
    @(negedge clk);
    in_signed = 1'b0; in_a = 16'd999; in_b = 8'd4; in_start = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midreset_no_result", 32'(out_data_valid), 32'd0);
    check("midreset_idle", 32'(out_can_accept_cmd), 32'd1);

    $display("cmd post-reset s=0 a=10 b=3");
    run_cmd(1'b0, 16'd10, 8'd3, golden(1'b0, 16'd10, 8'd3), 1'b0);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
